// File: rtl/stream_demux.sv
// Receive-side demultiplexer for the 4-source TS multiplex.
// Parses 4-byte header + 188-byte TS frames, routes forwarded payload bytes to one of four
// channels via a one-hot valid, checks the TS sync byte and PLP ID, and keeps error counters.
module stream_demux #(
    parameter int unsigned HDR_LEN   = 4,
    parameter int unsigned PKT_LEN   = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic [7:0]  DATA_IN,
    input  logic        D_VALID_IN,
    input  logic        P_SYNC_IN,
    input  logic [3:0]  CH_ENABLE,
    output logic [7:0]  DATA_OUT,
    output logic [3:0]  D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic [7:0]  PLP_ID_OUT,
    output logic [7:0]  STREAM_SRC_OUT,
    output logic [15:0] ERR_SYNC_CNT,
    output logic [15:0] ERR_PLP_CNT,
    output logic [15:0] PKT_CNT
);

    localparam int unsigned MaxLen = (PKT_LEN > HDR_LEN) ? PKT_LEN : HDR_LEN;
    localparam int unsigned CntW   = $clog2(MaxLen);
    localparam logic [CntW-1:0] HdrLast = CntW'(HDR_LEN - 1);
    localparam logic [CntW-1:0] PktLast = CntW'(PKT_LEN - 1);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StDiscard} state_e;

    state_e          state_q;
    logic [CntW-1:0] bcnt_q;
    logic            gap_q;
    logic [7:0]      plp_q;
    logic [7:0]      src_q;
    logic [1:0]      ch_q;
    logic [7:0]      data_out_q;
    logic [3:0]      dvalid_q;
    logic            psync_q;
    logic [7:0]      plp_out_q;
    logic [7:0]      src_out_q;
    logic [15:0]     err_sync_q;
    logic [15:0]     err_plp_q;
    logic [15:0]     pkt_q;

    // Framing ignores the packet-sync input entirely; only the gap rule delimits frames.
    logic unused_p_sync;
    assign unused_p_sync = P_SYNC_IN;

    // Frame parser, router and counters; every output is a register.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            bcnt_q     <= '0;
            gap_q      <= 1'b1;
            plp_q      <= '0;
            src_q      <= '0;
            ch_q       <= '0;
            data_out_q <= '0;
            dvalid_q   <= '0;
            psync_q    <= 1'b0;
            plp_out_q  <= '0;
            src_out_q  <= '0;
            err_sync_q <= '0;
            err_plp_q  <= '0;
            pkt_q      <= '0;
        end else begin
            // Valid/sync strobes last exactly one cycle per forwarded byte.
            dvalid_q <= '0;
            psync_q  <= 1'b0;
            if (!D_VALID_IN) begin
                // Any idle cycle arms the next frame start.
                gap_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Valid bytes not preceded by a gap are stray and dropped.
                        if (gap_q) begin
                            plp_q   <= DATA_IN;
                            bcnt_q  <= CntW'(1);
                            state_q <= StHeader;
                        end
                    end
                    StHeader: begin
                        if (bcnt_q == CntW'(1)) begin
                            src_q <= DATA_IN;
                        end
                        if (bcnt_q == HdrLast) begin
                            plp_out_q <= plp_q;
                            src_out_q <= src_q;
                            ch_q      <= plp_q[1:0];
                            bcnt_q    <= '0;
                            if (plp_q > 8'd3) begin
                                if (err_plp_q != 16'hFFFF) begin
                                    err_plp_q <= err_plp_q + 16'd1;
                                end
                                state_q <= StDiscard;
                            end else if (!CH_ENABLE[plp_q[1:0]]) begin
                                state_q <= StDiscard;
                            end else begin
                                state_q <= StPayload;
                            end
                        end else begin
                            bcnt_q <= bcnt_q + CntW'(1);
                        end
                    end
                    StPayload: begin
                        if (bcnt_q == '0 && DATA_IN != SYNC_BYTE) begin
                            // Bad sync: drop this byte and the rest of the packet.
                            if (err_sync_q != 16'hFFFF) begin
                                err_sync_q <= err_sync_q + 16'd1;
                            end
                            bcnt_q  <= CntW'(1);
                            state_q <= StDiscard;
                        end else begin
                            data_out_q <= DATA_IN;
                            dvalid_q   <= 4'(1) << ch_q;
                            psync_q    <= (bcnt_q == '0);
                            if (bcnt_q == PktLast) begin
                                pkt_q   <= pkt_q + 16'd1;
                                bcnt_q  <= '0;
                                gap_q   <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                bcnt_q <= bcnt_q + CntW'(1);
                            end
                        end
                    end
                    StDiscard: begin
                        if (bcnt_q == PktLast) begin
                            bcnt_q  <= '0;
                            gap_q   <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            bcnt_q <= bcnt_q + CntW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign DATA_OUT       = data_out_q;
    assign D_VALID_OUT    = dvalid_q;
    assign P_SYNC_OUT     = psync_q;
    assign PLP_ID_OUT     = plp_out_q;
    assign STREAM_SRC_OUT = src_out_q;
    assign ERR_SYNC_CNT   = err_sync_q;
    assign ERR_PLP_CNT    = err_plp_q;
    assign PKT_CNT        = pkt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux: frames are described at packet level, the
// expected forwarded bytes are queued when issued, and a negedge monitor checks DUT output.
module tb_stream_demux;

    localparam int unsigned PKT = 188;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        dvalid_in;
    logic        psync_in;
    logic [3:0]  ch_en;
    logic [7:0]  data_out;
    logic [3:0]  dvalid_out;
    logic        psync_out;
    logic [7:0]  plp_out;
    logic [7:0]  src_out;
    logic [15:0] err_sync;
    logic [15:0] err_plp;
    logic [15:0] pkt_cnt;

    stream_demux dut (
        .SYS_CLK        (clk),
        .RST            (rst_n),
        .DATA_IN        (data_in),
        .D_VALID_IN     (dvalid_in),
        .P_SYNC_IN      (psync_in),
        .CH_ENABLE      (ch_en),
        .DATA_OUT       (data_out),
        .D_VALID_OUT    (dvalid_out),
        .P_SYNC_OUT     (psync_out),
        .PLP_ID_OUT     (plp_out),
        .STREAM_SRC_OUT (src_out),
        .ERR_SYNC_CNT   (err_sync),
        .ERR_PLP_CNT    (err_plp),
        .PKT_CNT        (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] data;
        logic       psync;
        int         stamp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;

    // Reference state at frame level.
    logic [15:0] m_err_sync = '0;
    logic [15:0] m_err_plp  = '0;
    logic [15:0] m_pkt      = '0;
    logic [7:0]  m_plp      = '0;
    logic [7:0]  m_src      = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Monitor: every forwarded byte must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (dvalid_out != 4'd0 || psync_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {20'd0, dvalid_out, data_out}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid", 32'(dvalid_out), 32'(e.vld));
                check("out_data", 32'(data_out), 32'(e.data));
                check("out_psync", 32'(psync_out), 32'(e.psync));
                check("out_latency", 32'(cyc_cnt), 32'(e.stamp));
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d);
        dvalid_in = v;
        data_in   = v ? d : 8'($urandom);
        psync_in  = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic maybe_gap(input int pct);
        if (int'($urandom_range(99)) < pct) begin
            repeat ($urandom_range(1, 3)) cyc(1'b0, 8'h00);
        end
    endtask

    // Issue one frame; the fate of the frame is decided from the frame rules alone.
    task automatic send_frame(input logic [7:0] plp, input logic [7:0] src, input logic [7:0] b0,
                              input int lead, input int gap_pct, input int cut,
                              input int toggle_at, input bit junk);
        bit         fwd;
        logic [7:0] d;
        exp_t       e;
        repeat (lead) cyc(1'b0, 8'h00);
        fwd = 1'b0;
        if (plp > 8'd3) m_err_plp = sat_inc(m_err_plp);
        else if (ch_en[plp[1:0]]) begin
            if (b0 != 8'h47) m_err_sync = sat_inc(m_err_sync);
            else fwd = 1'b1;
        end
        m_plp = plp;
        m_src = src;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) maybe_gap(gap_pct);
            d = (i == 0) ? plp : (i == 1) ? src : 8'($urandom);
            cyc(1'b1, d);
        end
        for (int i = 0; i < cut; i++) begin
            maybe_gap(gap_pct);
            if (i == toggle_at) ch_en = ~ch_en;
            d = (i == 0) ? b0 : 8'($urandom);
            if (fwd) begin
                e.vld   = 4'(1) << plp[1:0];
                e.data  = d;
                e.psync = (i == 0);
                e.stamp = cyc_cnt + 1;
                exp_q.push_back(e);
            end
            cyc(1'b1, d);
        end
        if (fwd && cut == PKT) m_pkt = m_pkt + 16'd1;
        if (junk) repeat (3) cyc(1'b1, 8'h47);
    endtask

    task automatic check_regs(input string tag);
        repeat (2) cyc(1'b0, 8'h00);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_plp_id"}, 32'(plp_out), 32'(m_plp));
        check({tag, "_stream_src"}, 32'(src_out), 32'(m_src));
        check({tag, "_err_sync"}, 32'(err_sync), 32'(m_err_sync));
        check({tag, "_err_plp"}, 32'(err_plp), 32'(m_err_plp));
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(m_pkt));
    endtask

    initial begin
        rst_n     = 1'b0;
        dvalid_in = 1'b0;
        data_in   = 8'h00;
        psync_in  = 1'b0;
        ch_en     = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {data_out, dvalid_out, psync_out, plp_out, src_out}, 32'd0);
        check("reset_counters", {err_sync, err_plp}, 32'd0);
        check("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic frame to channel 1.
        send_frame(8'd1, 8'd3, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t1");

        // Back-to-back frames on each channel with single-cycle gaps.
        for (int p = 0; p < 4; p++) send_frame(8'(p), 8'($urandom), 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t2");

        // Out-of-range PLP ID, then a good frame.
        send_frame(8'd5, 8'h22, 8'h47, 1, 0, PKT, -1, 1'b0);
        send_frame(8'd2, 8'h33, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t3");

        // Bad sync byte, then a good frame.
        send_frame(8'd3, 8'h44, 8'h46, 2, 0, PKT, -1, 1'b0);
        send_frame(8'd0, 8'h55, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t4");

        // Disabled channel discards; enable change mid-packet does not cut the packet.
        ch_en = 4'b1101;
        send_frame(8'd1, 8'h66, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t5a");
        send_frame(8'd0, 8'h77, 8'h47, 1, 0, PKT, 50, 1'b0);
        check_regs("t5b");
        ch_en = 4'hF;

        // Stray valid bytes without a preceding gap are ignored.
        send_frame(8'd2, 8'h88, 8'h47, 1, 20, PKT, -1, 1'b1);
        send_frame(8'd3, 8'h99, 8'h47, 1, 20, PKT, -1, 1'b0);
        check_regs("junk");

        // Randomized traffic.
        for (int k = 0; k < 16; k++) begin
            logic [7:0] plp;
            logic [7:0] b0;
            ch_en = 4'($urandom);
            plp   = ($urandom_range(9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(3));
            b0    = ($urandom_range(7) == 0) ? 8'($urandom) : 8'h47;
            send_frame(plp, 8'($urandom), b0, int'($urandom_range(1, 4)),
                       int'($urandom_range(30)), PKT, -1, 1'($urandom));
        end
        check_regs("rand");
        ch_en = 4'hF;

        // Reset in the middle of a payload.
        send_frame(8'd1, 8'hAB, 8'h47, 1, 0, 100, -1, 1'b0);
        cyc(1'b0, 8'h00);
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {data_out, dvalid_out, psync_out, plp_out, src_out}, 32'd0);
        check("midreset_counters", {err_sync, err_plp}, 32'd0);
        check("midreset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        m_err_sync = '0;
        m_err_plp  = '0;
        m_pkt      = '0;
        m_plp      = '0;
        m_src      = '0;
        repeat (2) cyc(1'b0, 8'h00);
        rst_n = 1'b1;
        send_frame(8'd2, 8'hCD, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("t6");

        // Counter boundaries: error counters saturate, packet counter wraps.
        force dut.err_sync_q = 16'hFFFE;
        force dut.err_plp_q  = 16'hFFFE;
        force dut.pkt_q      = 16'hFFFF;
        #1;
        release dut.err_sync_q;
        release dut.err_plp_q;
        release dut.pkt_q;
        m_err_sync = 16'hFFFE;
        m_err_plp  = 16'hFFFE;
        m_pkt      = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'd0, 8'h10, 8'h00, 1, 0, PKT, -1, 1'b0);
            send_frame(8'd9, 8'h11, 8'h47, 1, 0, PKT, -1, 1'b0);
            check_regs("sat");
        end
        send_frame(8'd3, 8'h12, 8'h47, 1, 0, PKT, -1, 1'b0);
        check_regs("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
